// File: rtl/m_ext_pkg.sv
// Shared definitions for the RV32M divide/remainder sequencer.
package m_ext_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] FUNCT3_REM  = 3'b110;
  localparam logic [2:0] FUNCT3_REMU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } div_state_t;

  // DIV and REM are signed. Anything with bit2 clear decodes as DIVU.
  function automatic logic is_signed_op(input logic [2:0] f3);
    return f3[2] & ~f3[0];
  endfunction

  // REM and REMU return the remainder. Every other code returns the quotient.
  function automatic logic is_rem_op(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;

  // Shift the next dividend bit into the partial remainder.
  // Subtract the divisor when it fits and record the quotient bit.
  always_comb begin
    shifted = {rem_in, quo_in[XLEN-1]};
    if (shifted >= {1'b0, divisor}) begin
      // The difference is below the divisor, so it fits in XLEN bits.
      rem_out = shifted[XLEN-1:0] - divisor;
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end else begin
      rem_out = shifted[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer for the execute stage.
// It runs an iterative restoring divider and holds the pipeline with stall.
module div_sequencer #(
  parameter int XLEN            = m_ext_pkg::XLEN,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import m_ext_pkg::*;

  localparam int CALC_CYCLES = XLEN / STEPS_PER_CYCLE;
  localparam int CW          = $clog2(CALC_CYCLES + 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(CALC_CYCLES - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dsr_q;
  logic            neg_quo_q, neg_rem_q, sel_rem_q;

  logic            accept, op_signed, op_rem, div_by_zero, sgn_ovf, special;
  logic [XLEN-1:0] dividend_mag, divisor_mag, special_res;
  logic [XLEN-1:0] quo_fix, rem_fix, fix_res;

  logic [XLEN-1:0] rem_chain [STEPS_PER_CYCLE+1];
  logic [XLEN-1:0] quo_chain [STEPS_PER_CYCLE+1];

  // Decode the operation and the operands that are presented in IDLE.
  always_comb begin
    accept       = start & ~flush;
    op_signed    = is_signed_op(func3);
    op_rem       = is_rem_op(func3);
    div_by_zero  = (divisor == '0);
    sgn_ovf      = op_signed & (dividend == MIN_NEG) & (divisor == '1);
    special      = div_by_zero | sgn_ovf;
    dividend_mag = (op_signed & dividend[XLEN-1]) ? -dividend : dividend;
    divisor_mag  = (op_signed & divisor[XLEN-1])  ? -divisor  : divisor;
    special_res  = '0;
    if (div_by_zero)
      special_res = op_rem ? dividend : '1;
    else
      special_res = op_rem ? '0 : MIN_NEG;
  end

  // Chain STEPS_PER_CYCLE restoring steps from the registered partial state.
  assign rem_chain[0] = rem_q;
  assign quo_chain[0] = quo_q;

  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
    div_step #(.XLEN(XLEN)) u_step (
      .rem_in  (rem_chain[g]),
      .quo_in  (quo_chain[g]),
      .divisor (dsr_q),
      .rem_out (rem_chain[g+1]),
      .quo_out (quo_chain[g+1])
    );
  end

  // Restore the signs and select the quotient or the remainder.
  always_comb begin
    quo_fix = neg_quo_q ? -quo_q : quo_q;
    rem_fix = neg_rem_q ? -rem_q : rem_q;
    fix_res = sel_rem_q ? rem_fix : quo_fix;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic. Flush returns to IDLE from any state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_CALC;
      ST_CALC: begin
        if (flush)                  state_d = ST_IDLE;
        else if (cnt_q == LAST_CNT) state_d = ST_FIX;
      end
      ST_FIX:  state_d = flush ? ST_IDLE : ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, counter, and result register.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt_q     <= '0;
      result    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            rem_q     <= '0;
            quo_q     <= dividend_mag;
            dsr_q     <= divisor_mag;
            neg_quo_q <= op_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_rem_q <= op_signed & dividend[XLEN-1];
            sel_rem_q <= op_rem;
            if (special) result <= special_res;
          end
        end
        ST_CALC: begin
          rem_q <= rem_chain[STEPS_PER_CYCLE];
          quo_q <= quo_chain[STEPS_PER_CYCLE];
          cnt_q <= (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
        end
        ST_FIX: begin
          if (!flush) result <= fix_res;
        end
        default: ;
      endcase
      if (flush) cnt_q <= '0;
    end
  end

  // Status outputs. Stall is forced low while reset is asserted.
  always_comb begin
    busy  = (state_q != ST_IDLE);
    done  = (state_q == ST_DONE);
    stall = RESET & (((state_q == ST_IDLE) & start & ~flush) |
                     (state_q == ST_CALC) | (state_q == ST_FIX));
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed and random checks of div_sequencer against a behavioural divide model.
module tb_div_sequencer;
  import m_ext_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        stall, busy, done;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] res;
    int unsigned lat;
  } exp_t;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  div_sequencer #(.XLEN(32), .STEPS_PER_CYCLE(1)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .func3(func3),
    .dividend(dividend), .divisor(divisor), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .result(result)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic sgn, rem;
    logic signed [31:0] sa, sd;
    sgn = f3[2] & ~f3[0];
    rem = f3[2] & f3[1];
    sa = a;
    sd = b;
    if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
    if (sgn) return rem ? 32'(sa % sd) : 32'(sa / sd);
    return rem ? a % b : a / b;
  endfunction

  function automatic int unsigned ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Start one op, hold start until done as the stalled pipeline does, then drop it in DONE.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b);
    exp_t e, got;
    int unsigned cyc;
    bit stall_ok, seen;
    e.res = ref_result(f3, a, b);
    e.lat = ref_latency(f3, a, b);
    sb.push_back(e);
    @(negedge CLK);
    start = 1'b1; func3 = f3; dividend = a; divisor = b;
    #1;
    stall_ok = (stall === 1'b1);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge CLK); #1;
      cyc++;
      if (done === 1'b1) begin
        seen = 1'b1;
        if (stall !== 1'b0) stall_ok = 1'b0;
      end else if (stall !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    got = sb.pop_front();
    check32({tag, " result"}, result, got.res);
    check32({tag, " latency"}, cyc, got.lat);
    check32({tag, " stall profile"}, 32'(stall_ok), 32'd1);
    @(negedge CLK);
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit no_done;
    logic [2:0]  f3;
    logic [31:0] a, b;

    // Reset, with a start present to show stall is held low.
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    start = 1'b1; func3 = FUNCT3_DIVU; dividend = 32'd100; divisor = 32'd7;
    #1;
    check32("reset stall", 32'(stall), 32'd0);
    check32("reset busy", 32'(busy), 32'd0);
    check32("reset done", 32'(done), 32'd0);
    check32("reset result", result, 32'd0);
    @(negedge CLK);
    start = 1'b0;
    RESET = 1'b1;

    // Directed ops; consecutive calls give the minimum one-cycle gap.
    do_op("DIVU 100/7", FUNCT3_DIVU, 32'd100, 32'd7);
    do_op("REMU 100/7", FUNCT3_REMU, 32'd100, 32'd7);
    do_op("DIV -7/2", FUNCT3_DIV, 32'hFFFF_FFF9, 32'd2);
    do_op("REM -7/2", FUNCT3_REM, 32'hFFFF_FFF9, 32'd2);
    do_op("DIV 7/-2", FUNCT3_DIV, 32'd7, 32'hFFFF_FFFE);
    do_op("DIVU x/0", FUNCT3_DIVU, 32'h1234, 32'd0);
    do_op("REM x/0", FUNCT3_REM, 32'h1234, 32'd0);
    do_op("DIV -5/0", FUNCT3_DIV, 32'hFFFF_FFFB, 32'd0);
    do_op("REM ovf", FUNCT3_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("DIVU big/-1", FUNCT3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("illegal f3 as DIVU", 3'b001, 32'd100, 32'd7);
    do_op("DIV ovf", FUNCT3_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

    // Start together with flush in IDLE is not accepted.
    @(negedge CLK);
    start = 1'b1; flush = 1'b1; func3 = FUNCT3_DIVU; dividend = 32'd9; divisor = 32'd3;
    #1;
    check32("start+flush stall", 32'(stall), 32'd0);
    @(posedge CLK); #1;
    check32("start+flush busy", 32'(busy), 32'd0);
    @(negedge CLK);
    start = 1'b0; flush = 1'b0;

    // Flush mid-CALC: no done, old result kept.
    @(negedge CLK);
    start = 1'b1; func3 = FUNCT3_DIV; dividend = 32'd50; divisor = 32'd5;
    no_done = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge CLK); #1;
      if (done === 1'b1) no_done = 1'b0;
    end
    @(negedge CLK);
    flush = 1'b1; start = 1'b0;
    @(posedge CLK); #1;
    check32("flush stall", 32'(stall), 32'd0);
    check32("flush busy", 32'(busy), 32'd0);
    check32("flush result kept", result, 32'h8000_0000);
    @(negedge CLK);
    flush = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (done === 1'b1) no_done = 1'b0;
    end
    check32("flush no done", 32'(no_done), 32'd1);
    do_op("DIVU 9/3 after flush", FUNCT3_DIVU, 32'd9, 32'd3);

    // Reset mid-CALC.
    @(negedge CLK);
    start = 1'b1; func3 = FUNCT3_DIVU; dividend = 32'hFFFF; divisor = 32'd3;
    no_done = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); #1;
      if (done === 1'b1) no_done = 1'b0;
    end
    @(negedge CLK);
    RESET = 1'b0; start = 1'b0;
    #1;
    check32("in-reset stall", 32'(stall), 32'd0);
    @(posedge CLK); #1;
    check32("post-reset busy", 32'(busy), 32'd0);
    check32("post-reset result", result, 32'd0);
    check32("post-reset stall", 32'(stall), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (done === 1'b1) no_done = 1'b0;
    end
    check32("reset no done", 32'(no_done), 32'd1);

    // Random sweep with occasional zero, small, and overflow operands.
    for (int n = 0; n < 150; n++) begin
      f3 = 3'(4 + $urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op("random", f3, a, b);
    end

    check32("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
